// File: rtl/uart_cmd_ctrl_pkg.sv
// Package uart_cmd_pkg: shared ASCII key codes, the RX FSM state encoding, the
// BCD digit type and a helper that turns a BCD digit pair into a binary value.
// Imported by uart_rx_core and uart_cmd_ctrl.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  typedef logic [3:0] bcd_t;

  localparam logic [7:0] KEY_SPACE = 8'h20;
  localparam logic [7:0] KEY_ENTER = 8'h0D;
  localparam logic [7:0] KEY_BKSP  = 8'h08;
  localparam logic [7:0] KEY_S     = 8'h73;
  localparam logic [7:0] KEY_S_UC  = 8'h53;
  localparam logic [7:0] KEY_U     = 8'h75;
  localparam logic [7:0] KEY_PLUS  = 8'h2B;
  localparam logic [7:0] KEY_D     = 8'h64;
  localparam logic [7:0] KEY_MINUS = 8'h2D;
  localparam logic [7:0] KEY_0     = 8'h30;
  localparam logic [7:0] KEY_9     = 8'h39;

  localparam logic [6:0] MAX_SEC = 7'd59;

  // 10*hi + lo, with 10*hi built as (hi<<3)+(hi<<1); max 99 fits in 7 bits.
  function automatic logic [6:0] bcd_pair(input bcd_t hi, input bcd_t lo);
    logic [6:0] h;
    h = {3'b000, hi};
    return (h << 3) + (h << 1) + {3'b000, lo};
  endfunction

endpackage

// File: rtl/uart_cmd_ctrl_if.sv
// Interface uart_cmd_ctrl_if: groups the serial input, the running flag and all
// command/load outputs of uart_cmd_ctrl.
//   slave  : the controller (receives rx/running, drives the outputs)
//   master : the board-side user (drives rx/running, observes the outputs)
interface uart_cmd_ctrl_if;
  logic       rx;
  logic       running;
  logic       kb_start;
  logic       kb_stop;
  logic       kb_up;
  logic       kb_dwn;
  logic [5:0] load_minutes;
  logic [5:0] load_seconds;
  logic       load_valid;
  logic       load_err;
  logic       frame_err;
  logic [7:0] rx_byte;

  modport slave (
    input  rx, running,
    output kb_start, kb_stop, kb_up, kb_dwn,
    output load_minutes, load_seconds, load_valid, load_err,
    output frame_err, rx_byte
  );

  modport master (
    output rx, running,
    input  kb_start, kb_stop, kb_up, kb_dwn,
    input  load_minutes, load_seconds, load_valid, load_err,
    input  frame_err, rx_byte
  );
endinterface

// File: rtl/uart_cmd_ctrl_rx_core.sv
// uart_rx_core: rx synchroniser, oversampling tick generator and UART RX FSM.
// Optional macro UART_PARITY_EN adds an even-parity bit after the data bits.
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   rx_i              raw serial input (idle high)
//   byte_o            received byte, zero-extended to 8 bits
//   byte_done_o       1 in the stop-sample cycle of a good frame
//   frame_err_o       1 in the stop-sample cycle of a bad frame
module uart_rx_core
  import uart_cmd_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_done_o,
  output logic       frame_err_o
);
  localparam int unsigned DIV   = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned OS_W  = $clog2(OVERSAMPLE);

  logic             sync1_q, sync2_q;
  logic [DIV_W-1:0] div_q;
  rx_state_e        state_q, state_d;
  logic [OS_W-1:0]  os_q, os_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             armed_q, armed_d;
`ifdef UART_PARITY_EN
  logic             par_err_q, par_err_d;
`endif

  logic rx_s, tick;
  assign rx_s = sync2_q;
  assign tick = (div_q == DIV_W'(DIV - 1));
  assign byte_o = shift_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      div_q   <= '0;
      state_q <= RX_IDLE;
      os_q    <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      armed_q <= 1'b1;
`ifdef UART_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      div_q   <= tick ? '0 : div_q + 1'b1;
      state_q <= state_d;
      os_q    <= os_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      armed_q <= armed_d;
`ifdef UART_PARITY_EN
      par_err_q <= par_err_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    os_d        = os_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    armed_d     = armed_q;
    byte_done_o = 1'b0;
    frame_err_o = 1'b0;
`ifdef UART_PARITY_EN
    par_err_d   = par_err_q;
`endif
    case (state_q)
      RX_IDLE: begin
        // After a low stop bit (e.g. a break) the line must go high again
        // before a new start edge is accepted.
        if (rx_s) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d = RX_START;
          os_d    = '0;
        end
      end
      RX_START: begin
        if (tick) begin
          if (os_q == OS_W'(OVERSAMPLE / 2 - 1)) begin
            os_d = '0;
            if (rx_s) begin
              state_d = RX_IDLE;
            end else begin
              state_d = RX_DATA;
              bit_d   = '0;
              shift_d = '0;
            end
          end else begin
            os_d = os_q + 1'b1;
          end
        end
      end
      RX_DATA: begin
        if (tick) begin
          if (os_q == OS_W'(OVERSAMPLE - 1)) begin
            os_d           = '0;
            shift_d[bit_q] = rx_s;
            if (bit_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
              state_d = RX_PARITY;
`else
              state_d = RX_STOP;
`endif
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end else begin
            os_d = os_q + 1'b1;
          end
        end
      end
`ifdef UART_PARITY_EN
      RX_PARITY: begin
        if (tick) begin
          if (os_q == OS_W'(OVERSAMPLE - 1)) begin
            os_d      = '0;
            par_err_d = (rx_s != ^shift_q);
            state_d   = RX_STOP;
          end else begin
            os_d = os_q + 1'b1;
          end
        end
      end
`endif
      RX_STOP: begin
        if (tick) begin
          if (os_q == OS_W'(OVERSAMPLE - 1)) begin
            os_d    = '0;
            state_d = RX_IDLE;
            if (!rx_s) begin
              frame_err_o = 1'b1;
              armed_d     = 1'b0;
`ifdef UART_PARITY_EN
            end else if (par_err_q) begin
              frame_err_o = 1'b1;
`endif
            end else begin
              byte_done_o = 1'b1;
            end
          end else begin
            os_d = os_q + 1'b1;
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end
endmodule

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: keyboard command front-end. Receives UART bytes through
// uart_rx_core, decodes keys into one-cycle command pulses and assembles
// "MMSS"+Enter into range-checked minutes/seconds load values.
// Optional macro UART_PARITY_EN enables an even-parity bit on the line.
// Ports:
//   sys_clk, sys_rst  clock, asynchronous active-high reset
//   bus (slave)       rx, running in; kb_start/stop/up/dwn, load_minutes,
//                     load_seconds, load_valid, load_err, frame_err, rx_byte out
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned MAX_MIN    = 59
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  uart_cmd_ctrl_if.slave  bus
);
  localparam logic [6:0] MAX_MIN_7 = 7'(MAX_MIN);

  logic [7:0] core_byte;
  logic       core_done, core_ferr;

  uart_rx_core #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OVERSAMPLE),
    .DATA_BITS  (DATA_BITS)
  ) u_rx (
    .clk_i       (sys_clk),
    .rst_i       (sys_rst),
    .rx_i        (bus.rx),
    .byte_o      (core_byte),
    .byte_done_o (core_done),
    .frame_err_o (core_ferr)
  );

  logic            start_q, start_d, stop_q, stop_d, up_q, up_d, dwn_q, dwn_d;
  logic            lv_q, lv_d, le_q, le_d, fe_q, fe_d;
  logic [5:0]      min_q, min_d, sec_q, sec_d;
  logic [7:0]      byte_q, byte_d;
  bcd_t [3:0]      dig_q, dig_d;
  logic [6:0]      mins, secs;

  assign mins = bcd_pair(dig_q[3], dig_q[2]);
  assign secs = bcd_pair(dig_q[1], dig_q[0]);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      start_q <= 1'b0; stop_q <= 1'b0; up_q <= 1'b0; dwn_q <= 1'b0;
      lv_q    <= 1'b0; le_q   <= 1'b0; fe_q <= 1'b0;
      min_q   <= '0;   sec_q  <= '0;   byte_q <= '0;
      dig_q   <= '0;
    end else begin
      start_q <= start_d; stop_q <= stop_d; up_q <= up_d; dwn_q <= dwn_d;
      lv_q    <= lv_d;    le_q   <= le_d;   fe_q <= fe_d;
      min_q   <= min_d;   sec_q  <= sec_d;  byte_q <= byte_d;
      dig_q   <= dig_d;
    end
  end

  always_comb begin
    start_d = 1'b0; stop_d = 1'b0; up_d = 1'b0; dwn_d = 1'b0;
    lv_d    = 1'b0; le_d   = 1'b0;
    fe_d    = core_ferr;
    min_d   = min_q;
    sec_d   = sec_q;
    byte_d  = byte_q;
    dig_d   = dig_q;
    if (core_done) begin
      byte_d = core_byte;
      case (core_byte)
        KEY_SPACE:         start_d = 1'b1;
        KEY_S, KEY_S_UC:   stop_d  = 1'b1;
        KEY_U, KEY_PLUS:   up_d    = 1'b1;
        KEY_D, KEY_MINUS:  dwn_d   = 1'b1;
        KEY_BKSP:          dig_d   = '0;
        KEY_ENTER: begin
          if (!bus.running) begin
            dig_d = '0;
            if (secs <= MAX_SEC && mins <= MAX_MIN_7) begin
              min_d = mins[5:0];
              sec_d = secs[5:0];
              lv_d  = 1'b1;
            end else begin
              le_d = 1'b1;
            end
          end
        end
        default: begin
          if (!bus.running && core_byte >= KEY_0 && core_byte <= KEY_9) begin
            dig_d = {dig_q[2:0], core_byte[3:0]};
          end
        end
      endcase
    end
  end

  assign bus.kb_start     = start_q;
  assign bus.kb_stop      = stop_q;
  assign bus.kb_up        = up_q;
  assign bus.kb_dwn       = dwn_q;
  assign bus.load_valid   = lv_q;
  assign bus.load_err     = le_q;
  assign bus.frame_err    = fe_q;
  assign bus.load_minutes = min_q;
  assign bus.load_seconds = sec_q;
  assign bus.rx_byte      = byte_q;
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
module tb_uart_cmd_ctrl;
  // Divisor 2000000/(62500*16) = 2 clocks per tick, 32 clocks per bit.
  localparam int BIT = 32;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  always #5 sys_clk = ~sys_clk;

  uart_cmd_ctrl_if bus ();

  uart_cmd_ctrl #(
    .CLK_HZ     (2_000_000),
    .BAUD       (62_500),
    .OVERSAMPLE (16),
    .DATA_BITS  (8),
    .MAX_MIN    (59)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Pulse counters: start, stop, up, dwn, load_valid, load_err, frame_err
  int cnt [7];
  always @(negedge sys_clk) begin
    cnt[0] = cnt[0] + int'(bus.kb_start);
    cnt[1] = cnt[1] + int'(bus.kb_stop);
    cnt[2] = cnt[2] + int'(bus.kb_up);
    cnt[3] = cnt[3] + int'(bus.kb_dwn);
    cnt[4] = cnt[4] + int'(bus.load_valid);
    cnt[5] = cnt[5] + int'(bus.load_err);
    cnt[6] = cnt[6] + int'(bus.frame_err);
  end

  int base [7];

  task automatic snap();
    for (int i = 0; i < 7; i++) base[i] = cnt[i];
  endtask

  // Each pulse-count delta packed in a 4-bit field, clamped at 15.
  function automatic logic [27:0] deltas();
    logic [27:0] r;
    int d;
    r = '0;
    for (int i = 0; i < 7; i++) begin
      d = cnt[i] - base[i];
      if (d > 15) d = 15;
      if (d < 0) d = 15;
      r[(6-i)*4 +: 4] = 4'(d);
    end
    return r;
  endfunction

  function automatic logic [27:0] expand(input logic [6:0] f);
    logic [27:0] r;
    r = '0;
    for (int i = 0; i < 7; i++) r[(6-i)*4] = f[6-i];
    return r;
  endfunction

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    bus.rx = 1'b0;
    wclk(BIT);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      wclk(BIT);
    end
`ifdef UART_PARITY_EN
    bus.rx = ^b;
    wclk(BIT);
`endif
    bus.rx = stop_bit;
    wclk(BIT);
    bus.rx = 1'b1;
    wclk(BIT);
  endtask

`ifdef UART_PARITY_EN
  task automatic send_bad_parity(input logic [7:0] b);
    bus.rx = 1'b0;
    wclk(BIT);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      wclk(BIT);
    end
    bus.rx = ~(^b);
    wclk(BIT);
    bus.rx = 1'b1;
    wclk(2 * BIT);
  endtask
`endif

  function automatic logic [26:0] all_outs();
    return {bus.kb_start, bus.kb_stop, bus.kb_up, bus.kb_dwn, bus.load_valid,
            bus.load_err, bus.frame_err, bus.load_minutes, bus.load_seconds, bus.rx_byte};
  endfunction

  // flags: {start, stop, up, dwn, load_valid, load_err, frame_err}
  typedef struct {
    logic [7:0] b;
    logic       run;
    logic [6:0] flags;
    logic [5:0] mn;
    logic [5:0] sc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [7:0] b, input logic run, input logic [6:0] f,
                     input logic [5:0] mn, input logic [5:0] sc);
    vec_t v;
    v.b = b; v.run = run; v.flags = f; v.mn = mn; v.sc = sc;
    vecs.push_back(v);
  endtask

  initial begin
    for (int i = 0; i < 7; i++) cnt[i] = 0;
    bus.rx      = 1'b1;
    bus.running = 1'b0;

    add(8'h20, 0, 7'b1000000, 0, 0);
    add(8'h73, 0, 7'b0100000, 0, 0);
    add(8'h53, 0, 7'b0100000, 0, 0);
    add(8'h75, 0, 7'b0010000, 0, 0);
    add(8'h2B, 0, 7'b0010000, 0, 0);
    add(8'h64, 0, 7'b0001000, 0, 0);
    add(8'h2D, 0, 7'b0001000, 0, 0);
    add(8'h55, 0, 7'b0000000, 0, 0);
    // "0230" Enter -> 02:30
    add(8'h30, 0, 0, 0, 0); add(8'h32, 0, 0, 0, 0);
    add(8'h33, 0, 0, 0, 0); add(8'h30, 0, 0, 0, 0);
    add(8'h0D, 0, 7'b0000100, 2, 30);
    // "0175" Enter -> error, loads kept
    add(8'h30, 0, 0, 2, 30); add(8'h31, 0, 0, 2, 30);
    add(8'h37, 0, 0, 2, 30); add(8'h35, 0, 0, 2, 30);
    add(8'h0D, 0, 7'b0000010, 2, 30);
    // buffer was cleared by the rejected Enter -> 00:00
    add(8'h0D, 0, 7'b0000100, 0, 0);
    // "12" BS "5" Enter -> 00:05
    add(8'h31, 0, 0, 0, 0); add(8'h32, 0, 0, 0, 0);
    add(8'h08, 0, 0, 0, 0); add(8'h35, 0, 0, 0, 0);
    add(8'h0D, 0, 7'b0000100, 0, 5);
    // digits and Enter while running are discarded
    add(8'h30, 1, 0, 0, 5); add(8'h31, 1, 0, 0, 5);
    add(8'h30, 1, 0, 0, 5); add(8'h30, 1, 0, 0, 5);
    add(8'h0D, 1, 0, 0, 5);
    add(8'h0D, 0, 7'b0000100, 0, 0);
    // "130" Enter -> 01:30
    add(8'h31, 0, 0, 0, 0); add(8'h33, 0, 0, 0, 0); add(8'h30, 0, 0, 0, 0);
    add(8'h0D, 0, 7'b0000100, 1, 30);
    // "5959" -> 59:59 upper bound accepted
    add(8'h35, 0, 0, 1, 30); add(8'h39, 0, 0, 1, 30);
    add(8'h35, 0, 0, 1, 30); add(8'h39, 0, 0, 1, 30);
    add(8'h0D, 0, 7'b0000100, 59, 59);
    // "6000" -> minutes 60 rejected
    add(8'h36, 0, 0, 59, 59); add(8'h30, 0, 0, 59, 59);
    add(8'h30, 0, 0, 59, 59); add(8'h30, 0, 0, 59, 59);
    add(8'h0D, 0, 7'b0000010, 59, 59);
    // "0060" -> seconds 60 rejected
    add(8'h30, 0, 0, 59, 59); add(8'h30, 0, 0, 59, 59);
    add(8'h36, 0, 0, 59, 59); add(8'h30, 0, 0, 59, 59);
    add(8'h0D, 0, 7'b0000010, 59, 59);
    // backspace clears even while running
    add(8'h31, 0, 0, 59, 59); add(8'h32, 0, 0, 59, 59);
    add(8'h08, 1, 0, 59, 59);
    add(8'h0D, 0, 7'b0000100, 0, 0);
    // "12345": oldest digit dropped -> 23:45
    add(8'h31, 0, 0, 0, 0); add(8'h32, 0, 0, 0, 0); add(8'h33, 0, 0, 0, 0);
    add(8'h34, 0, 0, 0, 0); add(8'h35, 0, 0, 0, 0);
    add(8'h0D, 0, 7'b0000100, 23, 45);

    wclk(5);
    check("reset_outputs", 64'(all_outs()), 64'h0);
    sys_rst = 1'b0;
    wclk(2 * BIT);

    foreach (vecs[i]) begin
      bus.running = vecs[i].run;
      snap();
      send_byte(vecs[i].b, 1'b1);
      check($sformatf("row%0d_pulses", i), 64'(deltas()), 64'(expand(vecs[i].flags)));
      check($sformatf("row%0d_data", i), {44'h0, bus.rx_byte, bus.load_minutes, bus.load_seconds},
            {44'h0, vecs[i].b, vecs[i].mn, vecs[i].sc});
    end
    bus.running = 1'b0;

    // Stop bit low: frame_err only, rx_byte unchanged (last good 0x0D)
    snap();
    send_byte(8'h20, 1'b0);
    check("bad_stop_pulses", 64'(deltas()), 64'(expand(7'b0000001)));
    check("bad_stop_rx_byte", 64'(bus.rx_byte), 64'h0D);

    // 4-tick (8 clock) low glitch: no activity
    snap();
    bus.rx = 1'b0;
    wclk(8);
    bus.rx = 1'b1;
    wclk(3 * BIT);
    check("glitch_pulses", 64'(deltas()), 64'h0);
    check("glitch_rx_byte", 64'(bus.rx_byte), 64'h0D);

    // Break: long low line gives exactly one frame_err
    snap();
    bus.rx = 1'b0;
    wclk(25 * BIT);
    bus.rx = 1'b1;
    wclk(2 * BIT);
    check("break_pulses", 64'(deltas()), 64'(expand(7'b0000001)));
    snap();
    send_byte(8'h75, 1'b1);
    check("after_break_up", 64'(deltas()), 64'(expand(7'b0010000)));

    // Reset in the middle of the data bits of 's'
    snap();
    bus.rx = 1'b0;
    wclk(BIT);
    for (int i = 0; i < 8; i++) begin
      if (i == 4) sys_rst = 1'b1;
      bus.rx = (8'h73 >> i) & 8'h01;
      wclk(BIT);
    end
    bus.rx = 1'b1;
    wclk(BIT);
    check("midreset_outputs", 64'(all_outs()), 64'h0);
    sys_rst = 1'b0;
    wclk(2 * BIT);
    check("midreset_pulses", 64'(deltas()), 64'h0);
    snap();
    send_byte(8'h75, 1'b1);
    check("post_reset_up", 64'(deltas()), 64'(expand(7'b0010000)));
    check("post_reset_rx_byte", 64'(bus.rx_byte), 64'h75);

`ifdef UART_PARITY_EN
    snap();
    send_bad_parity(8'h20);
    check("bad_parity_pulses", 64'(deltas()), 64'(expand(7'b0000001)));
    check("bad_parity_rx_byte", 64'(bus.rx_byte), 64'h75);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
